// File: rtl/icache_dm_if.sv
// Bundles the fetch-side and memory-side line handshakes of icache_dm.
// slave is the cache's view; master is the requester/memory environment's view.
interface icache_dm_if #(
    parameter int ADDR_W = 64
);
    // Fetch side
    logic              enable;
    logic [ADDR_W-1:0] addr;
    logic              flush;
    logic [511:0]      rdata;
    logic              done;
    // Memory side
    logic              irequest;
    logic              ireqack;
    logic [ADDR_W-1:0] iaddr;
    logic [511:0]      idata;
    logic              idone;

    modport slave (
        input  enable, addr, flush, ireqack, idata, idone,
        output rdata, done, irequest, iaddr
    );

    modport master (
        output enable, addr, flush, ireqack, idata, idone,
        input  rdata, done, irequest, iaddr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with 64-byte lines, one-cycle hits and line refill.
// Optional hit/miss counters are compiled in with ICACHE_STATS_EN.
module icache_dm #(
    parameter int NUM_SETS = 64,
    parameter int ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    icache_dm_if.slave        bus,
    output logic [1:0]        dbg_state
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDR_W - 6 - INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_d [NUM_SETS];
    logic [511:0]        data_q [NUM_SETS];
    logic                drop_q, drop_d;
    logic                done_q, done_d;
    logic                irequest_q, irequest_d;
    logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
    logic [511:0]        rdata_q, rdata_d;

    logic [INDEX_W-1:0]  lk_idx, fill_idx;
    logic [TAG_W-1:0]    lk_tag, fill_tag;
    logic                lk_hit;
    logic                finish;
    logic                fill_we;

    assign lk_idx   = bus.addr[INDEX_W+5:6];
    assign lk_tag   = bus.addr[ADDR_W-1:INDEX_W+6];
    assign fill_idx = iaddr_q[INDEX_W+5:6];
    assign fill_tag = iaddr_q[ADDR_W-1:INDEX_W+6];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    // Memory handshake: irequest rises with iaddr and both hold until the edge
    // where ireqack=1; that edge is the transfer. idone is a one-cycle data pulse
    // that counts only in WAIT, or in REQ on the same edge as ireqack.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        drop_d     = drop_q;
        done_d     = 1'b0;
        irequest_d = irequest_q;
        iaddr_d    = iaddr_q;
        rdata_d    = rdata_q;
        finish     = 1'b0;
        fill_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end else if (bus.enable) begin
                    if (lk_hit) begin
                        rdata_d = data_q[lk_idx];
                        done_d  = 1'b1;
                    end else begin
                        irequest_d = 1'b1;
                        iaddr_d    = bus.addr;
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.ireqack) begin
                    irequest_d = 1'b0;
                    if (bus.idone) finish = 1'b1;
                    else           state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.idone) finish = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && bus.flush) begin
            valid_d = '0;
            drop_d  = 1'b1;
        end

        // A flush landing on the completion edge also blocks the install.
        if (finish) begin
            rdata_d = bus.idata;
            done_d  = 1'b1;
            drop_d  = 1'b0;
            state_d = S_IDLE;
            if (!drop_q && !bus.flush) begin
                fill_we           = 1'b1;
                valid_d[fill_idx] = 1'b1;
                tag_d[fill_idx]   = fill_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            drop_q     <= 1'b0;
            done_q     <= 1'b0;
            irequest_q <= 1'b0;
            iaddr_q    <= '0;
            rdata_q    <= '0;
            for (int i = 0; i < NUM_SETS; i++) tag_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            drop_q     <= drop_d;
            done_q     <= done_d;
            irequest_q <= irequest_d;
            iaddr_q    <= iaddr_d;
            rdata_q    <= rdata_d;
        end
    end

    // Data words carry no reset: a line is only ever read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_we) data_q[fill_idx] <= bus.idata;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == S_IDLE && !bus.flush && bus.enable) begin
            if (lk_hit) hit_count_d  = hit_count_q + 32'd1;
            else        miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

    assign bus.rdata    = rdata_q;
    assign bus.done     = done_q;
    assign bus.irequest = irequest_q;
    assign bus.iaddr    = iaddr_q;
    assign dbg_state    = state_q;

    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_IDLE && bus.enable && !bus.flush) |-> (bus.addr[5:0] == 6'd0))
        else $fatal(1, "icache_dm: enable with unaligned addr");

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: table of accesses plus hand-written
// sequences for back-to-back hits, flush in IDLE and reset during a refill.
module tb_icache_dm;
    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_dm_if #(.ADDR_W(64)) bus ();

    icache_dm #(.NUM_SETS(64), .ADDR_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    logic [511:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;
    int hits_exp   = 0;
    int misses_exp = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 expected no pending access");
            end else begin
                check("rdata", bus.rdata, exp_q.pop_front());
            end
        end
    end

    // Driver: one access from an IDLE negedge; returns on the negedge after done.
    task automatic do_access(input logic [63:0] a, input bit exp_hit, input logic [511:0] d,
                             input int ack_dly, input int done_dly, input bit flush_wait);
        exp_q.push_back(d);
        bus.enable = 1'b1;
        bus.addr   = a;
        @(negedge clk);
        bus.enable = 1'b0;
        if (exp_hit) begin
            hits_exp++;
            check("hit_done", 512'(bus.done), 512'(1));
            check("hit_no_req", 512'(bus.irequest), 512'(0));
        end else begin
            misses_exp++;
            check("miss_req", 512'(bus.irequest), 512'(1));
            check("miss_iaddr", 512'(bus.iaddr), 512'(a));
            check("miss_no_done", 512'(bus.done), 512'(0));
            for (int i = 0; i < ack_dly; i++) begin
                // idone without ireqack in REQ must be ignored
                bus.idone = (i == 0);
                bus.idata = ~d;
                @(negedge clk);
                bus.idone = 1'b0;
                check("req_hold", 512'(bus.irequest), 512'(1));
                check("req_iaddr_stable", 512'(bus.iaddr), 512'(a));
                check("req_no_done", 512'(bus.done), 512'(0));
            end
            bus.ireqack = 1'b1;
            bus.idata   = d;
            bus.idone   = (done_dly == 0);
            @(negedge clk);
            bus.ireqack = 1'b0;
            bus.idone   = 1'b0;
            check("ack_drops_req", 512'(bus.irequest), 512'(0));
            if (done_dly == 0) begin
                check("fast_done", 512'(bus.done), 512'(1));
            end else begin
                if (flush_wait) bus.flush = 1'b1;
                for (int i = 1; i < done_dly; i++) begin
                    @(negedge clk);
                    bus.flush = 1'b0;
                    check("wait_no_done", 512'(bus.done), 512'(0));
                end
                bus.idone = 1'b1;
                @(negedge clk);
                bus.idone = 1'b0;
                bus.flush = 1'b0;
                check("refill_done", 512'(bus.done), 512'(1));
            end
        end
    endtask

    task automatic check_stats();
`ifdef ICACHE_STATS_EN
        check("hit_count", 512'(hit_count), 512'(hits_exp));
        check("miss_count", 512'(miss_count), 512'(misses_exp));
`endif
    endtask

    typedef struct {
        logic [63:0]  addr;
        bit           hit;
        logic [511:0] data;
        int           ack_dly;
        int           done_dly;
        bit           flush_wait;
    } vec_t;

    vec_t vecs[15];
    logic [511:0] da, db, dc, dc2, dc3, dc4, de;
    logic [63:0]  a_top;

    initial begin
        da  = {8{64'hAAAA_0001_1111_0001}};
        db  = {8{64'hBBBB_0002_2222_0002}};
        dc  = {8{64'hCCCC_0003_3333_0003}};
        dc2 = {8{64'hC2C2_0004_4444_0004}};
        dc3 = {8{64'hC3C3_0005_5555_0005}};
        dc4 = {8{64'hC4C4_0006_6666_0006}};
        de  = {8{64'hEEEE_0007_7777_0007}};
        a_top = 64'hFFFF_FFFF_FFFF_FFC0;

        vecs[0]  = '{64'h1000, 1'b0, da,  3, 2, 1'b0}; // cold miss
        vecs[1]  = '{64'h1000, 1'b1, da,  0, 0, 1'b0};
        vecs[2]  = '{64'h2000, 1'b0, db,  1, 1, 1'b0}; // conflict, evicts 0x1000
        vecs[3]  = '{64'h2000, 1'b1, db,  0, 0, 1'b0};
        vecs[4]  = '{64'h1000, 1'b0, da,  0, 0, 1'b0}; // ack and idone together
        vecs[5]  = '{64'h1000, 1'b1, da,  0, 0, 1'b0};
        vecs[6]  = '{64'h2000, 1'b0, db,  0, 3, 1'b0};
        vecs[7]  = '{a_top,    1'b0, de,  2, 1, 1'b0}; // top index, all-ones tag
        vecs[8]  = '{a_top,    1'b1, de,  0, 0, 1'b0};
        vecs[9]  = '{64'h1000, 1'b0, da,  0, 1, 1'b0};
        vecs[10] = '{64'h0040, 1'b0, dc,  1, 2, 1'b1}; // flush in WAIT
        vecs[11] = '{64'h0040, 1'b0, dc2, 0, 0, 1'b0};
        vecs[12] = '{64'h1000, 1'b0, da,  0, 1, 1'b0};
        vecs[13] = '{64'h0040, 1'b1, dc2, 0, 0, 1'b0};
        vecs[14] = '{a_top,    1'b0, de,  0, 1, 1'b0};

        rst_n       = 1'b0;
        bus.enable  = 1'b0;
        bus.addr    = '0;
        bus.flush   = 1'b0;
        bus.ireqack = 1'b0;
        bus.idata   = '0;
        bus.idone   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_done", 512'(bus.done), 512'(0));
        check("rst_irequest", 512'(bus.irequest), 512'(0));
        check("rst_iaddr", 512'(bus.iaddr), 512'(0));
        check("rst_rdata", bus.rdata, 512'(0));
        check("rst_state", 512'(dbg_state), 512'(0));
        check_stats();

        for (int i = 0; i < 15; i++)
            do_access(vecs[i].addr, vecs[i].hit, vecs[i].data,
                      vecs[i].ack_dly, vecs[i].done_dly, vecs[i].flush_wait);
        check_stats();

        // Back-to-back hits: enable held, done every cycle
        exp_q.push_back(dc2);
        bus.enable = 1'b1;
        bus.addr   = 64'h0040;
        @(negedge clk);
        check("b2b_done0", 512'(bus.done), 512'(1));
        exp_q.push_back(da);
        bus.addr = 64'h1000;
        @(negedge clk);
        bus.enable = 1'b0;
        check("b2b_done1", 512'(bus.done), 512'(1));
        hits_exp += 2;

        // Flush in IDLE wins over enable
        bus.flush  = 1'b1;
        bus.enable = 1'b1;
        bus.addr   = 64'h0040;
        @(negedge clk);
        bus.flush  = 1'b0;
        bus.enable = 1'b0;
        check("flush_idle_no_done", 512'(bus.done), 512'(0));
        check("flush_idle_no_req", 512'(bus.irequest), 512'(0));
        do_access(64'h0040, 1'b0, dc3, 0, 0, 1'b0);
        check_stats();

        // Reset while waiting for refill data
        bus.enable = 1'b1;
        bus.addr   = 64'h1040;
        @(negedge clk);
        bus.enable = 1'b0;
        check("rm_req", 512'(bus.irequest), 512'(1));
        bus.ireqack = 1'b1;
        @(negedge clk);
        bus.ireqack = 1'b0;
        check("rm_in_wait", 512'(dbg_state), 512'(2));
        #2 rst_n = 1'b0;
        #1;
        check("rm_irequest", 512'(bus.irequest), 512'(0));
        check("rm_done", 512'(bus.done), 512'(0));
        check("rm_state", 512'(dbg_state), 512'(0));
        hits_exp   = 0;
        misses_exp = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_stats();
        bus.idone = 1'b1;
        bus.idata = dc;
        @(negedge clk);
        bus.idone = 1'b0;
        check("stray_idone_no_done", 512'(bus.done), 512'(0));
        do_access(64'h0040, 1'b0, dc4, 1, 1, 1'b0);
        do_access(64'h0040, 1'b1, dc4, 0, 0, 1'b0);
        check_stats();

        @(negedge clk);
        check("scoreboard_empty", 512'(exp_q.size()), 512'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
